// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared constants and response-owner encoding for the CPU data bus
package cpu_bus_pkg;

  localparam int STARVE_LIMIT_DEFAULT = 3;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

endpackage

// File: rtl/data_bus_arbiter.sv
// rtl/data_bus_arbiter.sv - two-master memory port arbiter with m1 starvation guard
// and a one-cycle registered read-response path.
module data_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_stall,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,

  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] LIMIT = 2'(STARVE_LIMIT);

  logic [1:0]  starve_q, starve_d;
  owner_e      owner_q, owner_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;

  logic        starved;
  logic        win_wr;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;

  assign starved = (starve_q == LIMIT);

  // Grant depends only on requests and registered state, never on rvalid.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!reset) begin
      m0_gnt = m0_req & ~(m1_req & starved);
      m1_gnt = m1_req & (~m0_req | starved);
    end
  end

  assign m0_stall = m0_req & ~m0_gnt & ~reset;

  always_comb begin
    win_wr    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    if (m0_gnt) begin
      win_wr    = m0_wr;
      win_addr  = m0_addr;
      win_wdata = m0_wdata;
    end else if (m1_gnt) begin
      win_wr    = m1_wr;
      win_addr  = m1_addr;
      win_wdata = m1_wdata;
    end
  end

  assign mem_wr    = (m0_gnt | m1_gnt) & win_wr;
  assign mem_rd    = (m0_gnt | m1_gnt) & ~win_wr;
  assign mem_addr  = win_addr;
  assign mem_wdata = win_wdata;

  // Any gap in m1's request restarts its starvation count.
  always_comb begin
    starve_d = starve_q;
    if (!m1_req || m1_gnt) begin
      starve_d = 2'd0;
    end else if (!starved) begin
      starve_d = starve_q + 2'd1;
    end
  end

  always_comb begin
    owner_d    = OWN_NONE;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    if (m0_gnt && !m0_wr) begin
      owner_d    = OWN_M0;
      m0_rdata_d = mem_rdata;
    end else if (m1_gnt && !m1_wr) begin
      owner_d    = OWN_M1;
      m1_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q   <= 2'd0;
      owner_q    <= OWN_NONE;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      starve_q   <= starve_d;
      owner_q    <= owner_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign m0_rvalid = (owner_q == OWN_M0);
  assign m1_rvalid = (owner_q == OWN_M1);
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb/tb_data_bus_arbiter.sv - scoreboard bench for data_bus_arbiter
module tb_data_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_stall, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    int          cyc;
    int          own;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
  } gev_t;

  typedef struct {
    int          cyc;
    int          own;
    logic [31:0] data;
  } rev_t;

  gev_t gq[$];
  rev_t rq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mm(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  assign mem_rdata = mm(mem_addr);

  data_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_stall(m0_stall), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or a read response.
  always @(negedge clk) begin
    if (!reset) begin
      if (m0_gnt || m1_gnt) begin
        if (gq.size() == 0) begin
          chk("unexpected_grant", {m0_gnt, m1_gnt}, 2'b00);
        end else begin
          gev_t g;
          g = gq.pop_front();
          chk("grant_cycle", 64'(cyc), 64'(g.cyc));
          chk("grant_owner", {m0_gnt, m1_gnt}, (g.own == 1) ? 2'b10 : 2'b01);
          chk("mem_strobes", {mem_rd, mem_wr}, {~g.wr, g.wr});
          chk("mem_addr", mem_addr, g.addr);
          chk("mem_wdata", mem_wdata, g.wd);
        end
      end else begin
        chk("idle_port", {mem_rd, mem_wr, mem_addr, mem_wdata[29:0]}, 64'd0);
      end
      if (m0_rvalid || m1_rvalid) begin
        if (rq.size() == 0) begin
          chk("unexpected_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
        end else begin
          rev_t r;
          r = rq.pop_front();
          chk("rvalid_cycle", 64'(cyc), 64'(r.cyc));
          chk("rvalid_owner", {m0_rvalid, m1_rvalid}, (r.own == 1) ? 2'b10 : 2'b01);
          chk("rdata", (r.own == 1) ? m0_rdata : m1_rdata, r.data);
        end
      end
    end
  end

  // exp: hand-computed winner, 0 = none, 1 = m0, 2 = m1.
  task automatic drive(input logic a_req, input logic a_wr, input logic [31:0] a_addr,
                       input logic [31:0] a_wd, input logic b_req, input logic b_wr,
                       input logic [31:0] b_addr, input logic [31:0] b_wd, input int exp);
    gev_t g;
    rev_t r;
    m0_req = a_req; m0_wr = a_wr; m0_addr = a_addr; m0_wdata = a_wd;
    m1_req = b_req; m1_wr = b_wr; m1_addr = b_addr; m1_wdata = b_wd;
    if (exp != 0) begin
      g.cyc  = cyc;
      g.own  = exp;
      g.wr   = (exp == 1) ? a_wr : b_wr;
      g.addr = (exp == 1) ? a_addr : b_addr;
      g.wd   = (exp == 1) ? a_wd : b_wd;
      gq.push_back(g);
      if (!g.wr) begin
        r.cyc  = cyc + 1;
        r.own  = exp;
        r.data = mm(g.addr);
        rq.push_back(r);
      end
    end
    #1;
    chk("m0_stall", m0_stall, a_req && (exp != 1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int seq[8];
    reset = 1'b1;
    m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    m0_req = 1'b1; m1_req = 1'b1;
    #1;
    chk("reset_grants", {m0_gnt, m1_gnt, m0_stall, mem_rd, mem_wr}, 5'b0);
    chk("reset_resp", {m0_rvalid, m1_rvalid, m0_rdata, m1_rdata}, 66'd0);
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    drive(1, 0, 32'h10, 32'h0, 0, 0, 0, 0, 1);
    idle();
    drive(0, 0, 0, 0, 1, 1, 32'h20, 32'h12345678, 2);
    idle();
    drive(1, 1, 32'h40, 32'hCAFEF00D, 0, 0, 0, 0, 1);
    idle();

    seq = '{1, 1, 1, 2, 1, 1, 1, 2};
    foreach (seq[i]) drive(1, 0, 32'h100, 0, 1, 0, 32'h200, 0, seq[i]);
    idle();

    drive(1, 0, 32'h104, 0, 1, 0, 32'h204, 0, 1);
    drive(1, 0, 32'h104, 0, 1, 0, 32'h204, 0, 1);
    drive(1, 0, 32'h108, 0, 0, 0, 32'h204, 0, 1);
    seq = '{1, 1, 1, 2, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++) drive(1, 0, 32'h10C, 0, 1, 0, 32'h208, 0, seq[i]);
    idle();

    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) drive(1, 0, 32'h300 + 32'(i * 4), 0, 0, 0, 0, 0, 1);
      else            drive(0, 0, 0, 0, 1, 0, 32'h400 + 32'(i * 4), 0, 2);
    end
    idle();

    drive(0, 0, 0, 0, 1, 0, 32'h480, 0, 2);
    drive(0, 0, 0, 0, 1, 1, 32'h484, 32'hA5A5A5A5, 2);
    idle();
    chk("m1_rdata_hold", m1_rdata, mm(32'h480));

    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h30;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_grants", {m0_gnt, m1_gnt, m0_stall, mem_rd}, 4'b0);
    chk("rst_mid_resp", {m0_rvalid, m1_rvalid, m0_rdata, m1_rdata}, 66'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_rvalid", {m0_rvalid, m1_rvalid, m0_gnt}, 3'b0);
    m0_req = 1'b0;
    reset = 1'b0;
    idle();
    idle();
    drive(0, 0, 0, 0, 1, 0, 32'h500, 0, 2);
    repeat (3) idle();

    chk("grants_left", 64'(gq.size()), 64'd0);
    chk("resps_left", 64'(rq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: the number of consecutive denied cycles of m1 after which m1 wins the next contested cycle.
REQ-002 clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 m0_req  input  1  CPU MEM-stage access request (priority requester).
REQ-005 m0_wr  input  1  m0 access type: 1 = write, 0 = read.
REQ-006 m0_addr  input  32  m0 byte address.
REQ-007 m0_wdata  input  32  m0 write data.
REQ-008 m0_gnt  output  1  m0 access performed this cycle.
REQ-009 m0_stall  output  1  equals m0_req AND NOT m0_gnt; drives the pipeline freeze.
REQ-010 m0_rvalid  output  1  m0 read data valid (one cycle after the grant).
REQ-011 m0_rdata  output  32  m0 read data.
REQ-012 m1_req, m1_wr, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same widths and meanings for the UART/DMA requester; m1 has no stall output.
REQ-013 mem_rd  output  1  memory read strobe.
REQ-014 mem_wr  output  1  memory write strobe.
REQ-015 mem_addr  output  32  memory address.
REQ-016 mem_wdata  output  32  memory write data.
REQ-017 mem_rdata  input  32  combinational read data from the memory for the current mem_addr.

Function
REQ-018 Grant SHALL be combinational from the req inputs and the registered state, so that at most one of m0_gnt and m1_gnt is high in any cycle.
REQ-019 Only m0_req is high -> m0_gnt=1; only m1_req is high -> m1_gnt=1; neither is high -> both grants 0 and both mem strobes 0.
REQ-020 Both req are high and starve_cnt < STARVE_LIMIT -> m0 SHALL win.
REQ-021 Both req are high and starve_cnt == STARVE_LIMIT -> m1 SHALL win.
REQ-022 starve_cnt (2-bit) update rules:
- increments each cycle that m1_req=1 and m1_gnt=0;
- saturates at STARVE_LIMIT;
- clears to 0 on any m1_gnt;
- clears to 0 on any cycle with m1_req=0.
REQ-023 Granted requester drives the memory port in the same cycle:
- mem_addr and mem_wdata come from the winner;
- mem_wr = winner_wr;
- mem_rd = NOT winner_wr.
REQ-024 With no grant, mem_addr and mem_wdata SHALL be 0.
REQ-025 A requester SHALL hold req, wr, addr and wdata stable until it sees gnt; the arbiter does not latch ungranted requests.
REQ-026 Read response path:
- on a granted read, mem_rdata is registered, together with the owner id, at the end of the grant cycle;
- next cycle, rvalid=1 for that owner only;
- rdata holds the registered value until the next granted read to that owner.
REQ-027 A granted write SHALL produce no rvalid pulse.
REQ-028 Back-to-back granted reads SHALL give back-to-back rvalid pulses with a fixed latency of 1 cycle.
REQ-029 The grant decision uses registered state only (no combinational loop through rvalid); throughput is one access per cycle.

Reset
REQ-030 While reset=1, and immediately on its assertion:
- starve_cnt=0;
- response owner and valid cleared;
- m0_rvalid = m1_rvalid = 0;
- m0_rdata = m1_rdata = 0.
REQ-031 Grant, strobe and stall outputs SHALL stay combinational during reset but SHALL be forced to 0 while reset=1.
REQ-032 A read granted in the cycle reset asserts SHALL NOT produce rvalid after reset release.

Structure
REQ-033 STARVE_LIMIT default and the owner encoding (OWN_NONE=0, OWN_M0=1, OWN_M1=2) SHALL live in the shared package cpu_bus_pkg.
REQ-034 No sub-module: the block is a single module containing the grant logic, the starvation counter and the response register.

Verification
REQ-035 m0 read alone at addr 0x10, mem_rdata=0xDEADBEEF -> m0_gnt=1 and mem_rd=1 in the same cycle; m0_rvalid=1 and m0_rdata=0xDEADBEEF next cycle; m1_rvalid stays 0.
REQ-036 m0_req and m1_req held high continuously (both reads) -> grant sequence m0, m0, m0, m1, m0, m0, m0, m1; m1 is never denied more than 3 consecutive cycles.
REQ-037 m1 write alone, addr 0x20, wdata 0x12345678 -> mem_wr=1, mem_addr=0x20, mem_wdata=0x12345678 for exactly one cycle; no rvalid.
REQ-038 m1 denied twice, then m1_req dropped for one cycle, then both req again -> starve_cnt restarts from 0 and m0 wins the next 3 contested cycles.
REQ-039 Assert reset in a cycle with a granted m0 read -> m0_rvalid stays 0 during reset and after release; all grants are 0 while reset=1.
REQ-040 Alternating m0 read and m1 read every cycle -> m0_rvalid and m1_rvalid alternate each cycle with rdata matching the memory value of the previous cycle.
